// File: rtl/nrzi_rx_decoder_if.sv
// Output word port of the NRZI receiver: valid/ready handshake carrying one decoded word.
// The master drives data_out and data_valid. The slave is the consumer and drives data_ready.
interface nrzi_rx_decoder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder.
// - Each strobed line sample is decoded as line XOR previous line.
// - The decoder hunts for SYNC_WORD, then deserialises FRAME_WORDS words LSB-first.
// - Completed words go out on a valid/ready port.
// Optional feature, enabled by defining the PARITY_CHECK_EN macro: every word carries one
// trailing even-parity bit, and a failing word raises a one-cycle parity_err pulse.
module nrzi_rx_decoder #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
  parameter int unsigned      FRAME_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      line_in,
  nrzi_rx_decoder_if.master         out_if,
  output logic                      overrun,
  output logic                      in_frame,
  output logic                      parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned WordBits = WIDTH + 1;
`else
  localparam int unsigned WordBits = WIDTH;
`endif
  localparam int unsigned BitCntW  = $clog2(WordBits + 1);
  localparam int unsigned WordCntW = $clog2(FRAME_WORDS + 1);

  localparam logic [0:0] StHunt = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  logic                prev_line_q, prev_line_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [BitCntW-1:0]  bitcnt_q, bitcnt_d;
  logic [WordCntW-1:0] wordcnt_q, wordcnt_d;
  logic [0:0]          state_q, state_d;
  logic [WIDTH-1:0]    data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                overrun_q, overrun_d;
  logic                in_frame_q, in_frame_d;
  logic                parity_err_q, parity_err_d;

  logic                bit_in;
  logic [WIDTH-1:0]    shifted;
  logic                word_done;
  logic [WIDTH-1:0]    word;
  logic                perr;

  // Bit recovery, sync hunt, word assembly, and output handshake.
  always_comb begin
    bit_in      = line_in ^ prev_line_q;
    shifted     = {bit_in, shreg_q[WIDTH-1:1]};
    prev_line_d = prev_line_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    wordcnt_d   = wordcnt_q;
    state_d     = state_q;
    word_done   = 1'b0;
    word        = shifted;
    perr        = 1'b0;

    if (en) begin
      prev_line_d = line_in;
      case (state_q)
        StHunt: begin
          shreg_d = shifted;
          if (shifted == SYNC_WORD) begin
            state_d   = StRecv;
            bitcnt_d  = '0;
            wordcnt_d = '0;
          end
        end
        default: begin
`ifdef PARITY_CHECK_EN
          // The parity bit is not shifted in, so shreg keeps the whole data word.
          if (bitcnt_q == BitCntW'(WIDTH)) begin
            word_done = 1'b1;
            word      = shreg_q;
            perr      = (^shreg_q) ^ bit_in;
          end else begin
            shreg_d  = shifted;
            bitcnt_d = bitcnt_q + 1'b1;
          end
`else
          shreg_d = shifted;
          if (bitcnt_q == BitCntW'(WIDTH - 1)) begin
            word_done = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
`endif
          if (word_done) begin
            bitcnt_d = '0;
            if (wordcnt_q == WordCntW'(FRAME_WORDS - 1)) begin
              state_d   = StHunt;
              shreg_d   = '0;
              wordcnt_d = '0;
            end else begin
              wordcnt_d = wordcnt_q + 1'b1;
            end
          end
        end
      endcase
    end

    // The handshake runs every cycle, independent of en.
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q & ~out_if.data_ready;
    overrun_d    = overrun_q;
    if (word_done) begin
      if (!data_valid_q || out_if.data_ready) begin
        data_out_d   = word;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    parity_err_d = word_done & perr;
    in_frame_d   = (state_d == StRecv);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_line_q  <= 1'b0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      wordcnt_q    <= '0;
      state_q      <= StHunt;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      in_frame_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      prev_line_q  <= prev_line_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      wordcnt_q    <= wordcnt_d;
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      in_frame_q   <= in_frame_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign out_if.data_out   = data_out_q;
  assign out_if.data_valid = data_valid_q;
  assign overrun           = overrun_q;
  assign in_frame          = in_frame_q;
  assign parity_err        = parity_err_q;

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder (WIDTH=8, SYNC_WORD=8'hA5, FRAME_WORDS=4).
// A reference T-flip-flop encoder drives the line.
module tb_nrzi_rx_decoder;

  logic clk = 1'b0;
  logic rst, en, line_in;
  logic overrun, in_frame, parity_err;
  logic line_q;
  int   checks   = 0;
  int   failures = 0;

  nrzi_rx_decoder_if #(.WIDTH(8)) bus ();

  nrzi_rx_decoder #(
    .WIDTH       (8),
    .SYNC_WORD   (8'hA5),
    .FRAME_WORDS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .line_in    (line_in),
    .out_if     (bus),
    .overrun    (overrun),
    .in_frame   (in_frame),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       accept;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    logic       exp_frame;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; en = 1'b0; line_q = 1'b0; line_in = 1'b0; bus.data_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One encoded bit on one en=1 cycle; with gap, an extra en=0 cycle carries a garbage line level.
  task automatic send_bit(input logic b, input bit gap);
    line_q = line_q ^ b;
    line_in = line_q;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    if (gap) begin
      line_in = ~line_q;
      @(posedge clk);
      #1 line_in = line_q;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit gap, input bit ready_last,
                           input bit par_flip);
    for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
      if (i == 7 && ready_last) bus.data_ready = 1'b1;
`endif
      send_bit(w[i], gap);
    end
`ifdef PARITY_CHECK_EN
    if (ready_last) bus.data_ready = 1'b1;
    send_bit((^w) ^ par_flip, gap);
`endif
    bus.data_ready = 1'b0;
  endtask

  task automatic accept();
    bus.data_ready = 1'b1;
    @(posedge clk);
    #1 bus.data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{word: 8'h3C, accept: 1'b1, exp_data: 8'h3C, exp_valid: 1'b1, exp_ovr: 1'b0,
                exp_frame: 1'b1};
    vecs[1] = '{word: 8'h11, accept: 1'b0, exp_data: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b0,
                exp_frame: 1'b1};
    vecs[2] = '{word: 8'h22, accept: 1'b0, exp_data: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b1,
                exp_frame: 1'b1};
    vecs[3] = '{word: 8'h99, accept: 1'b1, exp_data: 8'h11, exp_valid: 1'b1, exp_ovr: 1'b1,
                exp_frame: 1'b0};

    // Reset and en=0 immunity.
    do_reset(2);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_in_frame", in_frame, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      line_in = ~line_in;
      @(posedge clk);
      #1;
    end
    line_in = 1'b0;
    check("en0_in_frame", in_frame, 1'b0);
    check("en0_valid", bus.data_valid, 1'b0);

    // Sync, then a table-driven frame covering delivery and overrun.
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check("sync_in_frame", in_frame, 1'b1);
    check("sync_not_output", bus.data_valid, 1'b0);
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].word, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_data", v), bus.data_out, vecs[v].exp_data);
      check($sformatf("vec%0d_valid", v), bus.data_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_overrun", v), overrun, vecs[v].exp_ovr);
      check($sformatf("vec%0d_in_frame", v), in_frame, vecs[v].exp_frame);
      check($sformatf("vec%0d_parity_err", v), parity_err, 1'b0);
      if (vecs[v].accept) begin
        accept();
        check($sformatf("vec%0d_acc_valid", v), bus.data_valid, 1'b0);
        check($sformatf("vec%0d_acc_overrun", v), overrun, vecs[v].exp_ovr);
      end
    end

    // Simultaneous accept on the completion edge, frame end, and resync with en toggling.
    do_reset(2);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    check("simacc_first", bus.data_out, 8'h11);
    send_word(8'h22, 1'b0, 1'b1, 1'b0);
    check("simacc_data", bus.data_out, 8'h22);
    check("simacc_valid", bus.data_valid, 1'b1);
    check("simacc_overrun", overrun, 1'b0);
    accept();
    send_word(8'h44, 1'b0, 1'b0, 1'b0);
    accept();
    send_word(8'h88, 1'b0, 1'b0, 1'b0);
    check("fourth_data", bus.data_out, 8'h88);
    check("frame_end_in_frame", in_frame, 1'b0);
    accept();
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    check("fifth_no_valid", bus.data_valid, 1'b0);
    check("fifth_in_frame", in_frame, 1'b0);
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    check("gap_sync_in_frame", in_frame, 1'b1);
    check("gap_sync_not_output", bus.data_valid, 1'b0);
    send_word(8'h77, 1'b1, 1'b0, 1'b0);
    check("gap_data", bus.data_out, 8'h77);
    check("gap_valid", bus.data_valid, 1'b1);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    do_reset(1);
    check("midrst_valid", bus.data_valid, 1'b0);
    check("midrst_data", bus.data_out, 8'h00);
    check("midrst_in_frame", in_frame, 1'b0);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check("midrst_sync_valid", bus.data_valid, 1'b0);
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    check("midrst_word_data", bus.data_out, 8'h0F);
    check("midrst_word_valid", bus.data_valid, 1'b1);
    accept();
    check("midrst_acc_valid", bus.data_valid, 1'b0);

    // Parity handling (a parity bit is only sent when the feature is built in).
    send_word(8'h03, 1'b0, 1'b0, 1'b1);
`ifdef PARITY_CHECK_EN
    check("par_bad_pulse", parity_err, 1'b1);
`else
    check("par_tied_low", parity_err, 1'b0);
`endif
    check("par_bad_data", bus.data_out, 8'h03);
    check("par_bad_valid", bus.data_valid, 1'b1);
    @(posedge clk);
    #1;
    check("par_pulse_end", parity_err, 1'b0);
    accept();
    send_word(8'h03, 1'b0, 1'b0, 1'b0);
    check("par_good_no_pulse", parity_err, 1'b0);
    check("par_good_data", bus.data_out, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
